// File: rtl/tube_readout_ctrl.sv
// Tube readout controller: opens a drift window on all Tube channels, snapshots
// their counts, then streams one word per channel (or only hit channels) over a
// valid/ready interface, tagging each frame with an 8-bit frame number.
module tube_readout_ctrl #(
  parameter int unsigned NTUBES     = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned WINDOW     = 200,
  parameter int unsigned SKIP_EMPTY = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  trigger,
  input  logic [8*NTUBES-1:0]   tube_data,
  output logic                  tube_clr,
  output logic                  gate_enable,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_tube,
  output logic [7:0]            out_count,
  output logic                  out_hit,
  output logic                  out_last,
  output logic [7:0]            out_frame,
  output logic                  frame_done
);

  localparam logic [7:0] WinVal  = 8'(WINDOW);
  localparam logic [7:0] WinLast = 8'(WINDOW - 1);

  typedef enum logic [1:0] {StIdle, StArm, StSnap, StRead} state_e;

  state_e                   state_q, state_d;
  logic [7:0]               win_q, win_d;
  logic [7:0]               frame_q, frame_d;
  logic [NTUBES-1:0][7:0]   snap_q, snap_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     done_q, done_d;

  logic [NTUBES-1:0]        data_emit, snap_emit;
  logic [IDX_W:0]           first_scan, next_scan;
  logic                     xfer;

  // Lowest set index of mask at or above start; MSB flags whether one exists.
  function automatic logic [IDX_W:0] scan_from(input logic [NTUBES-1:0] mask, input int start);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = int'(NTUBES) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= start)) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  // Channels that produce a word: all of them, or only hit ones when skipping.
  always_comb begin
    data_emit = '0;
    snap_emit = '0;
    for (int i = 0; i < int'(NTUBES); i++) begin
      data_emit[i] = (SKIP_EMPTY == 0) || (tube_data[8*i +: 8] < WinVal);
      snap_emit[i] = (SKIP_EMPTY == 0) || (snap_q[i] < WinVal);
    end
    first_scan = scan_from(data_emit, 0);
    next_scan  = scan_from(snap_emit, int'(idx_q) + 1);
  end

  // Output decode; word fields are forced to zero whenever no word is offered.
  always_comb begin
    tube_clr    = (state_q != StArm);
    gate_enable = (state_q == StArm);
    busy        = (state_q != StIdle);
    out_valid   = (state_q == StRead);
    out_tube    = out_valid ? idx_q : '0;
    out_count   = out_valid ? snap_q[idx_q] : 8'd0;
    out_hit     = out_valid && (snap_q[idx_q] < WinVal);
    out_last    = out_valid && !next_scan[IDX_W];
    out_frame   = out_valid ? frame_q : 8'd0;
    frame_done  = done_q;
    xfer        = out_valid && out_ready;
  end

  // Next-state logic for the acquisition sequence.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    frame_d = frame_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StArm;
          frame_d = frame_q + 8'd1;
          win_d   = '0;
        end
      end
      StArm: begin
        if (win_q == WinLast) state_d = StSnap;
        else                  win_d   = win_q + 8'd1;
      end
      StSnap: begin
        snap_d = tube_data;
        if (first_scan[IDX_W]) begin
          idx_d   = first_scan[IDX_W-1:0];
          state_d = StRead;
        end else begin
          // Nothing to emit in this frame.
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StRead: begin
        if (xfer) begin
          if (next_scan[IDX_W]) begin
            idx_d = next_scan[IDX_W-1:0];
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      win_q   <= '0;
      frame_q <= '0;
      snap_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      frame_q <= frame_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/tube_readout_ctrl.md
TUBE_READOUT_CTRL -- requirements
Module: tube_readout_ctrl

Interface
REQ-001 Parameter NTUBES, default 8: number of Tube channels sequenced; legal range 2..16.
REQ-002 Parameter IDX_W, default 3: tube index width; SHALL satisfy 2**IDX_W >= NTUBES.
REQ-003 Parameter WINDOW, default 200: drift window length in clk cycles; legal range 1..254.
REQ-004 Parameter SKIP_EMPTY, default 0: when 1, channels with no hit are not emitted.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 clr  input  1  reset, synchronous and active-high.
REQ-007 trigger  input  1  start of acquisition; level sampled each cycle.
REQ-008 tube_data  input  8*NTUBES  packed counts from the Tube channels; channel i at bits [8i+7:8i].
REQ-009 tube_clr  output  1  drives the clr input of every Tube channel.
REQ-010 gate_enable  output  1  drives the gateEnable input of every Tube channel.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 out_valid  output  1  readout word valid.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_tube  output  IDX_W  channel index of the current word.
REQ-015 out_count  output  8  snapshot count of that channel.
REQ-016 out_hit  output  1  1 when out_count < WINDOW.
REQ-017 out_last  output  1  1 on the final word of a frame.
REQ-018 out_frame  output  8  frame number of the current word.
REQ-019 frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-020 FSM states: IDLE, ARM, SNAP, READ; transitions occur only on clk edges.
REQ-021 IDLE: tube_clr=1, gate_enable=0; when trigger=1, go to ARM, increment the frame counter, and load the window counter with 0.
REQ-022 ARM: tube_clr=0, gate_enable=1 for exactly WINDOW consecutive cycles; after the WINDOW-th cycle, go to SNAP.
REQ-023 SNAP (1 cycle): tube_clr=1, gate_enable=0; capture all of tube_data into an internal snapshot on the edge that leaves SNAP; an unhit channel thus snapshots exactly WINDOW.
REQ-024 READ: tube_clr=1; emit snapshot words in ascending index order 0..NTUBES-1.
REQ-025 With SKIP_EMPTY=1, skip any channel with snapshot >= WINDOW; skipping costs no cycle beyond the next emitted word.
REQ-026 A word is transferred on a cycle with out_valid=1 and out_ready=1; the next word presents on the following cycle (one word per cycle at full throughput).
REQ-027 While out_valid=1 and out_ready=0, out_tube, out_count, out_hit, out_last and out_frame SHALL hold stable.
REQ-028 out_last=1 only on the highest-index word to be emitted in the frame.
REQ-029 After the out_last transfer: pulse frame_done for one cycle, return to IDLE, and drop out_valid the same cycle.
REQ-030 SKIP_EMPTY=1 with no hits in the frame: emit no word, pulse frame_done on the cycle after SNAP, and return to IDLE.
REQ-031 Triggers while busy=1 SHALL be ignored, not queued; trigger held high re-arms only from IDLE.
REQ-032 A new frame may start on the cycle immediately following frame_done.
REQ-033 The frame counter is 8-bit and wraps 255->0; the first frame after reset is 1.
REQ-034 out_hit is combinational from out_count vs WINDOW, or registered with it; it is never misaligned with out_count.

Reset
REQ-035 When clr=1 on an edge, regardless of state: state=IDLE, tube_clr=1, gate_enable=0, busy=0, out_valid=0, out_tube=0, out_count=0, out_hit=0, out_last=0, out_frame=0, frame_done=0, frame counter=0, snapshot cleared.
REQ-036 A reset during ARM or READ abandons the frame without a frame_done pulse, and any word in flight is discarded.

Verification
REQ-037 Reset, then trigger pulse with channel 2 hit 50 cycles into the window and the others unhit, out_ready=1, SKIP_EMPTY=0 -> gate_enable high for exactly 200 cycles; 8 words with tube 0..7; tube 2 count=50, out_hit=1; others count=200, out_hit=0; out_last on tube 7; out_frame=1; one frame_done.
REQ-038 Same stimulus with SKIP_EMPTY=1 -> a single word with tube=2, count=50, out_last=1, then frame_done.
REQ-039 out_ready toggling 1,0,0,1 during READ -> each word is held stable while stalled; no word is lost or duplicated.
REQ-040 Trigger pulses during ARM and READ -> no effect on outputs; the frame counter advances only once.
REQ-041 clr asserted mid-READ (after 3 words) -> next cycle out_valid=0, tube_clr=1, busy=0, no frame_done; the next trigger yields out_frame=1.
REQ-042 256 back-to-back frames -> out_frame runs 1..255 then 0, with exactly one frame_done per frame.
